// File: rtl/aes_sbox_engine.sv
// AES byte-substitution engine: forward (SubBytes) or inverse (InvSubBytes)
// S-box applied to a 128-bit state, LANES bytes per clock, over a
// valid/ready handshake. The S-boxes are computed from GF(2^8) arithmetic
// (multiplicative inverse plus affine map) rather than stored as tables.
module aes_sbox_engine #(
    parameter int TEXT_WIDTH = 128,
    parameter int LANES      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  inv_i,
    input  logic [TEXT_WIDTH-1:0] text_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [TEXT_WIDTH-1:0] text_o
);

    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject unsupported configurations at elaboration time.
    if (TEXT_WIDTH != 128) begin : g_bad_width
        $error("aes_sbox_engine: TEXT_WIDTH must be 128");
    end
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (sh & {8{b[i]}});
            sh  = {sh[6:0], 1'b0} ^ (8'h1b & {8{sh[7]}});
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    // Rotate a byte left by n positions.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the inverse.
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] y;
        y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    state_t                r_state;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_mode;
    logic [CNT_W-1:0]      r_cnt;
    logic [TEXT_WIDTH-1:0] r_work;

    logic [7:0]            w_lane_in  [LANES];
    logic [7:0]            w_lane_out [LANES];
    logic [TEXT_WIDTH-1:0] w_work_next;
    logic                  w_last;

    assign w_last = (r_cnt == CNT_W'(STEPS - 1));

    // Gather the LANES bytes addressed by the current step (byte 0 is the MSB).
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[TEXT_WIDTH-1-8*(int'(r_cnt)*LANES+l) -: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] w_fwd;
        logic [7:0] w_inv;
        assign w_fwd         = sbox_fwd(w_lane_in[l]);
        assign w_inv         = sbox_inv(w_lane_in[l]);
        assign w_lane_out[l] = r_mode ? w_inv : w_fwd;
    end

    // Scatter substituted bytes back into a copy of the work register.
    always_comb begin
        w_work_next = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_next[TEXT_WIDTH-1-8*(int'(r_cnt)*LANES+l) -: 8] = w_lane_out[l];
        end
    end

    // Control FSM with registered handshake outputs and the datapath state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_work  <= {TEXT_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i && r_ready) begin
                        r_work  <= text_i;
                        r_mode  <= inv_i;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_ready <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= ST_BUSY;
                    end else begin
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_mode  <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_work  <= {TEXT_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign text_o  = r_work;

endmodule

// File: tb/tb_aes_sbox_engine.sv
// Self-checking bench for aes_sbox_engine: one instance per LANES value
// (1, 2, 4, 8, 16), compared against an S-box table built by brute force.
module tb_aes_sbox_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   vi, ii, ri, ro, vo;
    logic [127:0] ti [5];
    logic [127:0] to [5];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    // Free-running clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_sbox_engine #(.TEXT_WIDTH(128), .LANES(1 << g)) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (vi[g]),
            .ready_o (ro[g]),
            .inv_i   (ii[g]),
            .text_i  (ti[g]),
            .valid_o (vo[g]),
            .ready_i (ri[g]),
            .text_o  (to[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Polynomial product over GF(2) reduced modulo 0x11b, in plain integers.
    function automatic int pmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        end
        for (int bit_i = 14; bit_i >= 8; bit_i--) begin
            if (((p >> bit_i) & 1) == 1) p = p ^ (32'h11b << (bit_i - 8));
        end
        return p;
    endfunction

    function automatic int rot(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    // Fill forward and inverse tables: brute-force inverse, then affine map.
    task automatic build_tables();
        int inv_v;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv_v = 0;
            for (int y = 1; y < 256; y++) begin
                if (pmul(x, y) == 1) inv_v = y;
            end
            s = inv_v ^ rot(inv_v, 1) ^ rot(inv_v, 2) ^ rot(inv_v, 3) ^ rot(inv_v, 4) ^ 32'h63;
            sb[x]  = 8'(s);
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] t, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = 128'd0;
        for (int k = 0; k < 16; k++) begin
            b = t[127-8*k -: 8];
            r[127-8*k -: 8] = m ? isb[b] : sb[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one block into instance k (entered just after a negedge, engine idle).
    task automatic run_block(input int k, input logic [127:0] t, input logic m,
                             input string tag, output logic [127:0] res);
        int n;
        chk1({tag, "_rdy_before"}, ro[k], 1'b1);
        vi[k] = 1'b1;
        ti[k] = t;
        ii[k] = m;
        @(negedge clk);
        vi[k] = 1'b0;
        ti[k] = rnd128();
        ii[k] = ~m;
        chk1({tag, "_rdy_busy"}, ro[k], 1'b0);
        n = 0;
        while (vo[k] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chkn({tag, "_latency"}, n, 16 >> k);
        res = to[k];
        chk({tag, "_data"}, res, ref_sub(t, m));
        @(negedge clk);
        chk1({tag, "_valid_drop"}, vo[k], 1'b0);
        chk1({tag, "_rdy_after"}, ro[k], 1'b1);
    endtask

    // Runaway guard.
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Directed sequence of test steps.
    initial begin
        logic [127:0] pt, r1, r2, t, hold, exp;
        logic         m;
        int           n, results, accepted, last_acc;

        pt = 128'h000102030405060708090a0b0c0d0e0f;
        build_tables();

        rst_n = 1'b0;
        vi = 5'd0;
        ii = 5'd0;
        ri = 5'b11111;
        for (int k = 0; k < 5; k++) ti[k] = 128'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk1($sformatf("reset_ready_%0d", k), ro[k], 1'b1);
            chk1($sformatf("reset_valid_%0d", k), vo[k], 1'b0);
            chk($sformatf("reset_text_%0d", k), to[k], 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors on LANES=4.
        run_block(2, pt, 1'b0, "kat_fwd", r1);
        chk("kat_fwd_literal", r1, 128'h637c777bf26b6fc53001672bfed7ab76);
        run_block(2, pt, 1'b1, "kat_inv", r2);
        chk("kat_inv_literal", r2, 128'h52096ad53036a538bf40a39e81f3d7fb);

        // Round trip plus random blocks on every LANES value.
        for (int k = 0; k < 5; k++) begin
            run_block(k, pt, 1'b0, $sformatf("rt_fwd_L%0d", 1 << k), r1);
            run_block(k, r1, 1'b1, $sformatf("rt_inv_L%0d", 1 << k), r2);
            chk($sformatf("rt_back_L%0d", 1 << k), r2, pt);
            for (int j = 0; j < 3; j++) begin
                t = rnd128();
                m = 1'($urandom_range(0, 1));
                run_block(k, t, m, $sformatf("rand_L%0d_%0d", 1 << k, j), r1);
            end
        end

        // Backpressure on LANES=4 while the inputs are scrambled.
        t = rnd128();
        m = 1'($urandom_range(0, 1));
        exp = ref_sub(t, m);
        ri[2] = 1'b0;
        vi[2] = 1'b1;
        ti[2] = t;
        ii[2] = m;
        @(negedge clk);
        vi[2] = 1'b0;
        n = 0;
        while (vo[2] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chkn("bp_latency", n, 4);
        hold = to[2];
        chk("bp_first", hold, exp);
        for (int c = 0; c < 10; c++) begin
            chk1($sformatf("bp_valid_%0d", c), vo[2], 1'b1);
            chk1($sformatf("bp_ready_%0d", c), ro[2], 1'b0);
            chk($sformatf("bp_text_%0d", c), to[2], hold);
            vi[2] = 1'($urandom_range(0, 1));
            ti[2] = rnd128();
            ii[2] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("bp_text_end", to[2], exp);
        vi[2] = 1'b0;
        ri[2] = 1'b1;
        @(negedge clk);
        chk1("bp_release_valid", vo[2], 1'b0);
        chk1("bp_release_ready", ro[2], 1'b1);

        // Asynchronous reset in the middle of a LANES=1 block.
        vi[0] = 1'b1;
        ti[0] = rnd128() | 128'h1;
        ii[0] = 1'b0;
        @(negedge clk);
        vi[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_valid", vo[0], 1'b0);
        chk1("rst_mid_ready", ro[0], 1'b1);
        chk("rst_mid_text", to[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(0, {16{8'hff}}, 1'b0, "rst_ff", r1);
        chk("rst_ff_literal", r1, {16{8'h16}});

        // Back-to-back blocks on LANES=4 with valid held high, alternating mode.
        results = 0;
        accepted = 0;
        last_acc = 0;
        vi[2] = 1'b1;
        ri[2] = 1'b1;
        for (int cyc = 0; cyc < 200 && results < 4; cyc++) begin
            if (vo[2] === 1'b1) begin
                exp = (results % 2 == 0) ? 128'd0 : {16{8'h63}};
                chk($sformatf("b2b_data_%0d", results), to[2], exp);
                results++;
            end
            if (ro[2] === 1'b1 && accepted < 4) begin
                ti[2] = (accepted % 2 == 0) ? {16{8'h63}} : 128'd0;
                ii[2] = (accepted % 2 == 0) ? 1'b1 : 1'b0;
                if (accepted > 0) chkn($sformatf("b2b_period_%0d", accepted), cyc - last_acc, 6);
                last_acc = cyc;
                accepted++;
            end else if (accepted >= 4) begin
                vi[2] = 1'b0;
            end else begin
                ti[2] = rnd128();
                ii[2] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        chkn("b2b_results", results, 4);
        vi[2] = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
